// File: rtl/mem_pkg.sv
// Shared memory-interface types: access parameters, arbiter request/response
// records and the alignment check used before a request reaches mem.
package mem_pkg;

    typedef logic [31:0] arch_reg;

    typedef enum logic {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } mem_op_t;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'd0,
        MEM_ACCESS_HALF = 2'd1,
        MEM_ACCESS_WORD = 2'd2,
        MEM_ACCESS_RSVD = 2'd3
    } mem_access_size_t;

    typedef struct packed {
        mem_op_t          op;
        mem_access_size_t access_size;
        logic             sign_extend;
    } mem_params_t;

    typedef struct packed {
        arch_reg     address;
        arch_reg     wdata;
        mem_params_t params;
    } mem_req_t;

    typedef struct packed {
        arch_reg rdata;
        logic    error;
    } mem_resp_t;

    typedef enum logic {
        MEM_PORT_I = 1'b0,
        MEM_PORT_D = 1'b1
    } mem_port_t;

    // Harmless access presented to mem whenever nothing legal is granted.
    localparam mem_params_t MEM_IDLE_PARAMS = '{
        op:          MEM_OP_READ,
        access_size: MEM_ACCESS_WORD,
        sign_extend: 1'b0
    };

    function automatic logic mem_misaligned(input arch_reg address,
                                            input mem_access_size_t access_size);
        case (access_size)
            MEM_ACCESS_HALF: return address[0];
            MEM_ACCESS_WORD: return |address[1:0];
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_resp_buf.sv
// One-entry response register for one arbiter port; a load in the same
// cycle as a consume wins, so the entry stays valid with the new response.
module mem_resp_buf
    import mem_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      i_load,
    input  mem_resp_t i_load_resp,
    input  logic      i_consume,
    output logic      o_valid,
    output mem_resp_t o_resp
);

    logic      r_valid;
    mem_resp_t r_resp;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_resp  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_resp  <= i_load_resp;
        end else if (i_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_resp  = r_resp;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported mem between instruction fetch (I) and load/store (D),
// one grant per cycle, with a bounded D streak so I cannot starve.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req_valid,
    output logic        i_req_ready,
    input  mem_req_t    i_req,
    output logic        i_resp_valid,
    input  logic        i_resp_ready,
    output mem_resp_t   i_resp,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  mem_req_t    d_req,
    output logic        d_resp_valid,
    input  logic        d_resp_ready,
    output mem_resp_t   d_resp,
    output arch_reg     mem_address,
    output arch_reg     mem_data_in,
    output mem_params_t mem_params,
    input  arch_reg     mem_data_out
);

    localparam int         NPORTS     = 2;
    localparam int         P_I        = int'(MEM_PORT_I);
    localparam int         P_D        = int'(MEM_PORT_D);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    logic [3:0] r_streak;
    logic       w_req_valid  [NPORTS];
    logic       w_resp_ready [NPORTS];
    logic       w_eligible   [NPORTS];
    logic       w_load       [NPORTS];
    logic       w_buf_valid  [NPORTS];
    mem_resp_t  w_buf_resp   [NPORTS];
    logic       w_grant_i;
    logic       w_grant_d;
    logic       w_drive;
    logic       w_error;
    mem_req_t   w_sel_req;
    mem_resp_t  w_resp_next;

    assign w_req_valid[P_I]  = i_req_valid;
    assign w_req_valid[P_D]  = d_req_valid;
    assign w_resp_ready[P_I] = i_resp_ready;
    assign w_resp_ready[P_D] = d_resp_ready;
    assign w_load[P_I]       = w_grant_i;
    assign w_load[P_D]       = w_grant_d;

    // A full buffer that is drained this cycle frees its port for a new grant.
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        assign w_eligible[gi] = !reset && w_req_valid[gi]
                                && (!w_buf_valid[gi] || w_resp_ready[gi]);

        mem_resp_buf u_buf (
            .clock       (clock),
            .reset       (reset),
            .i_load      (w_load[gi]),
            .i_load_resp (w_resp_next),
            .i_consume   (w_resp_ready[gi]),
            .o_valid     (w_buf_valid[gi]),
            .o_resp      (w_buf_resp[gi])
        );
    end

    assign w_grant_d = w_eligible[P_D] && ((r_streak < STREAK_MAX) || !w_eligible[P_I]);
    assign w_grant_i = w_eligible[P_I] && !w_grant_d;

    assign w_sel_req = w_grant_d ? d_req : i_req;
    assign w_error   = (w_sel_req.params.access_size == MEM_ACCESS_RSVD)
                       || mem_misaligned(w_sel_req.address, w_sel_req.params.access_size)
                       || (w_grant_i && (w_sel_req.params.op == MEM_OP_WRITE));
    assign w_drive   = (w_grant_i || w_grant_d) && !w_error;

    always_comb begin
        mem_address = '0;
        mem_data_in = '0;
        mem_params  = MEM_IDLE_PARAMS;
        if (w_drive) begin
            mem_address = w_sel_req.address;
            mem_data_in = w_sel_req.wdata;
            mem_params  = w_sel_req.params;
        end
    end

    // Errored requests and writes return zero data; writes are a bare ack.
    always_comb begin
        w_resp_next.error = w_error;
        w_resp_next.rdata = mem_data_out;
        if (w_error || (w_sel_req.params.op == MEM_OP_WRITE)) begin
            w_resp_next.rdata = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_streak <= '0;
        end else if (!i_req_valid || w_grant_i) begin
            r_streak <= '0;
        end else if (w_grant_d && (r_streak < STREAK_MAX)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    assign i_req_ready  = w_grant_i;
    assign d_req_ready  = w_grant_d;
    assign i_resp_valid = w_buf_valid[P_I];
    assign d_resp_valid = w_buf_valid[P_D];
    assign i_resp       = w_buf_resp[P_I];
    assign d_resp       = w_buf_resp[P_D];

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a byte-array mem model, a table of single accesses,
// and hand sequences for back-to-back, streak, stall and reset behaviour.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_req_valid, i_req_ready, i_resp_valid, i_resp_ready;
    logic        d_req_valid, d_req_ready, d_resp_valid, d_resp_ready;
    mem_req_t    i_req, d_req;
    mem_resp_t   i_resp, d_resp;
    arch_reg     mem_address, mem_data_in, mem_data_out;
    mem_params_t mem_params;

    int total = 0;
    int bad   = 0;
    mem_resp_t q_i[$];
    mem_resp_t q_d[$];
    mem_resp_t e_i, e_d;

    typedef struct {
        bit               port_d;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        mem_op_t          op;
        mem_access_size_t size;
        logic             sext;
        logic [31:0]      exp_rdata;
        logic             exp_err;
    } vec_t;

    mem_arbiter #(.MAX_D_STREAK(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .i_req_ready  (i_req_ready),
        .i_req        (i_req),
        .i_resp_valid (i_resp_valid),
        .i_resp_ready (i_resp_ready),
        .i_resp       (i_resp),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req        (d_req),
        .d_resp_valid (d_resp_valid),
        .d_resp_ready (d_resp_ready),
        .d_resp       (d_resp),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_params   (mem_params),
        .mem_data_out (mem_data_out)
    );

    always #5 clock = ~clock;

    // Little-endian byte-array model of mem: combinational read, write at the edge.
    logic [7:0] mem_arr [0:1023];
    logic [9:0] ma;
    logic       tb_init;
    assign ma = mem_address[9:0];

    always_comb begin
        mem_data_out = '0;
        case (mem_params.access_size)
            MEM_ACCESS_BYTE: mem_data_out = {{24{mem_params.sign_extend & mem_arr[ma][7]}}, mem_arr[ma]};
            MEM_ACCESS_HALF: mem_data_out = {{16{mem_params.sign_extend & mem_arr[ma+10'd1][7]}},
                                             mem_arr[ma+10'd1], mem_arr[ma]};
            MEM_ACCESS_WORD: mem_data_out = {mem_arr[ma+10'd3], mem_arr[ma+10'd2],
                                             mem_arr[ma+10'd1], mem_arr[ma]};
            default: ;
        endcase
    end

    always @(posedge clock) begin
        if (tb_init) begin
            for (int k = 0; k < 1024; k++) mem_arr[k] <= 8'h00;
            mem_arr[10'h100] <= 8'hEF; mem_arr[10'h101] <= 8'hBE;
            mem_arr[10'h102] <= 8'hAD; mem_arr[10'h103] <= 8'hDE;
            mem_arr[10'h200] <= 8'h11; mem_arr[10'h201] <= 8'h22;
            mem_arr[10'h202] <= 8'h33; mem_arr[10'h203] <= 8'h44;
        end else if (mem_params.op == MEM_OP_WRITE) begin
            mem_arr[ma] <= mem_data_in[7:0];
            if (mem_params.access_size != MEM_ACCESS_BYTE) mem_arr[ma+10'd1] <= mem_data_in[15:8];
            if (mem_params.access_size == MEM_ACCESS_WORD) begin
                mem_arr[ma+10'd2] <= mem_data_in[23:16];
                mem_arr[ma+10'd3] <= mem_data_in[31:24];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, want);
        end
    endtask

    function automatic mem_req_t mk_req(input logic [31:0] a, input logic [31:0] wd,
                                        input mem_op_t op, input mem_access_size_t sz,
                                        input logic sx);
        mem_req_t r;
        r.address            = a;
        r.wdata              = wd;
        r.params.op          = op;
        r.params.access_size = sz;
        r.params.sign_extend = sx;
        return r;
    endfunction

    function automatic vec_t mk_vec(input bit pd, input logic [31:0] a, input logic [31:0] wd,
                                    input mem_op_t op, input mem_access_size_t sz, input logic sx,
                                    input logic [31:0] er, input logic ee);
        vec_t v;
        v.port_d = pd; v.addr = a; v.wdata = wd; v.op = op; v.size = sz; v.sext = sx;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    function automatic mem_resp_t mk_resp(input logic [31:0] rd, input logic er);
        mem_resp_t r;
        r.rdata = rd;
        r.error = er;
        return r;
    endfunction

    // Scoreboard: a response is compared in the cycle the bench consumes it.
    always @(negedge clock) begin
        if (!reset && i_resp_valid && i_resp_ready) begin
            if (q_i.size() == 0) chk("i_resp_unexpected", 1, 0);
            else begin
                e_i = q_i.pop_front();
                chk("i_resp", {31'd0, i_resp.error, i_resp.rdata}, {31'd0, e_i.error, e_i.rdata});
                $display("txn I resp rdata=%h err=%b", i_resp.rdata, i_resp.error);
            end
        end
        if (!reset && d_resp_valid && d_resp_ready) begin
            if (q_d.size() == 0) chk("d_resp_unexpected", 1, 0);
            else begin
                e_d = q_d.pop_front();
                chk("d_resp", {31'd0, d_resp.error, d_resp.rdata}, {31'd0, e_d.error, e_d.rdata});
                $display("txn D resp rdata=%h err=%b", d_resp.rdata, d_resp.error);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        mem_req_t r      = mk_req(v.addr, v.wdata, v.op, v.size, v.sext);
        logic     exp_wr = (v.op == MEM_OP_WRITE) && !v.exp_err;
        if (v.port_d) begin d_req = r; d_req_valid = 1'b1; end
        else          begin i_req = r; i_req_valid = 1'b1; end
        @(negedge clock);
        chk($sformatf("v%0d_ready", idx), v.port_d ? d_req_ready : i_req_ready, 1);
        chk($sformatf("v%0d_other_ready", idx), v.port_d ? i_req_ready : d_req_ready, 0);
        chk($sformatf("v%0d_mem_op", idx), mem_params.op, exp_wr ? MEM_OP_WRITE : MEM_OP_READ);
        chk($sformatf("v%0d_mem_addr", idx), mem_address, v.exp_err ? 32'd0 : v.addr);
        if (v.port_d) q_d.push_back(mk_resp(v.exp_rdata, v.exp_err));
        else          q_i.push_back(mk_resp(v.exp_rdata, v.exp_err));
        $display("txn vec %0d port=%s addr=%h op=%0d size=%0d", idx, v.port_d ? "D" : "I",
                 v.addr, v.op, v.size);
        next_cycle();
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        i_resp_ready = 1'b1; d_resp_ready = 1'b1;
        @(negedge clock);
        chk($sformatf("v%0d_resp_valid", idx), v.port_d ? d_resp_valid : i_resp_valid, 1);
        next_cycle();
        i_resp_ready = 1'b0; d_resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [12];
        tbl[0]  = mk_vec(0, 32'h100, 32'h0, MEM_OP_READ,  MEM_ACCESS_WORD, 0, 32'hDEADBEEF, 0);
        tbl[1]  = mk_vec(1, 32'h200, 32'h0, MEM_OP_READ,  MEM_ACCESS_WORD, 0, 32'hA5332211, 0);
        tbl[2]  = mk_vec(1, 32'h102, 32'h0, MEM_OP_READ,  MEM_ACCESS_WORD, 0, 32'h0, 1);
        tbl[3]  = mk_vec(0, 32'h100, 32'h0, MEM_OP_WRITE, MEM_ACCESS_WORD, 0, 32'h0, 1);
        tbl[4]  = mk_vec(0, 32'h100, 32'h0, MEM_OP_READ,  MEM_ACCESS_WORD, 0, 32'hDEADBEEF, 0);
        tbl[5]  = mk_vec(1, 32'h101, 32'h0, MEM_OP_READ,  MEM_ACCESS_HALF, 0, 32'h0, 1);
        tbl[6]  = mk_vec(1, 32'h100, 32'h0, MEM_OP_READ,  MEM_ACCESS_RSVD, 0, 32'h0, 1);
        tbl[7]  = mk_vec(1, 32'h102, 32'h0, MEM_OP_READ,  MEM_ACCESS_HALF, 0, 32'h0000DEAD, 0);
        tbl[8]  = mk_vec(1, 32'h204, 32'h8234, MEM_OP_WRITE, MEM_ACCESS_HALF, 0, 32'h0, 0);
        tbl[9]  = mk_vec(1, 32'h204, 32'h0, MEM_OP_READ,  MEM_ACCESS_HALF, 1, 32'hFFFF8234, 0);
        tbl[10] = mk_vec(1, 32'h206, 32'h5A5A5A5A, MEM_OP_WRITE, MEM_ACCESS_WORD, 0, 32'h0, 1);
        tbl[11] = mk_vec(1, 32'h206, 32'h0, MEM_OP_READ,  MEM_ACCESS_HALF, 0, 32'h0, 0);

        tb_init = 1'b1;
        reset = 1'b1;
        i_req_valid = 0; d_req_valid = 0; i_resp_ready = 0; d_resp_ready = 0;
        i_req = mk_req(0, 0, MEM_OP_READ, MEM_ACCESS_WORD, 0);
        d_req = mk_req(0, 0, MEM_OP_READ, MEM_ACCESS_WORD, 0);

        // Reset state, with requests present to show nothing is granted.
        next_cycle();
        tb_init = 1'b0;
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        d_req = mk_req(32'h200, 32'hFFFFFFFF, MEM_OP_WRITE, MEM_ACCESS_WORD, 0);
        @(negedge clock);
        chk("rst_i_req_ready", i_req_ready, 0);
        chk("rst_d_req_ready", d_req_ready, 0);
        chk("rst_i_resp_valid", i_resp_valid, 0);
        chk("rst_d_resp_valid", d_resp_valid, 0);
        chk("rst_i_resp", i_resp, 0);
        chk("rst_d_resp", d_resp, 0);
        chk("rst_mem_op", mem_params.op, MEM_OP_READ);
        chk("rst_mem_size", mem_params.access_size, MEM_ACCESS_WORD);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_data", mem_data_in, 0);
        next_cycle();
        reset = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;

        // D byte write then signed byte read of the same address on the next cycle.
        d_resp_ready = 1'b1; d_req_valid = 1'b1;
        d_req = mk_req(32'h203, 32'h000000A5, MEM_OP_WRITE, MEM_ACCESS_BYTE, 0);
        @(negedge clock);
        chk("b2b_wr_ready", d_req_ready, 1);
        chk("b2b_wr_op", mem_params.op, MEM_OP_WRITE);
        q_d.push_back(mk_resp(32'h0, 1'b0));
        next_cycle();
        d_req = mk_req(32'h203, 32'h0, MEM_OP_READ, MEM_ACCESS_BYTE, 1);
        @(negedge clock);
        chk("b2b_rd_ready", d_req_ready, 1);
        chk("b2b_resp_valid", d_resp_valid, 1);
        q_d.push_back(mk_resp(32'hFFFFFFA5, 1'b0));
        next_cycle();
        d_req_valid = 1'b0;
        @(negedge clock);
        chk("b2b_rd_resp_valid", d_resp_valid, 1);
        next_cycle();
        d_resp_ready = 1'b0;

        for (int k = 0; k < 12; k++) run_vec(tbl[k], k);

        // Both ports streaming: D gets four grants, then I is forced through.
        i_req_valid = 1'b1; d_req_valid = 1'b1; i_resp_ready = 1'b1; d_resp_ready = 1'b1;
        i_req = mk_req(32'h100, 32'h0, MEM_OP_READ, MEM_ACCESS_WORD, 0);
        d_req = mk_req(32'h200, 32'h0, MEM_OP_READ, MEM_ACCESS_WORD, 0);
        for (int k = 0; k < 10; k++) begin
            bit want_d;
            want_d = ((k % 5) != 4);
            @(negedge clock);
            chk($sformatf("streak%0d_d_ready", k), d_req_ready, want_d);
            chk($sformatf("streak%0d_i_ready", k), i_req_ready, !want_d);
            if (want_d) q_d.push_back(mk_resp(32'hA5332211, 1'b0));
            else        q_i.push_back(mk_resp(32'hDEADBEEF, 1'b0));
            $display("txn streak cycle %0d expect grant %s", k, want_d ? "D" : "I");
            next_cycle();
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clock);
        next_cycle();
        i_resp_ready = 1'b0; d_resp_ready = 1'b0;

        // D response held for three cycles; I keeps flowing meanwhile.
        d_req_valid = 1'b1; i_resp_ready = 1'b1;
        @(negedge clock);
        chk("stall_first_d_ready", d_req_ready, 1);
        q_d.push_back(mk_resp(32'hA5332211, 1'b0));
        next_cycle();
        i_req_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            chk($sformatf("stall%0d_d_ready", j), d_req_ready, 0);
            chk($sformatf("stall%0d_d_resp_valid", j), d_resp_valid, 1);
            chk($sformatf("stall%0d_d_rdata", j), d_resp.rdata, 32'hA5332211);
            chk($sformatf("stall%0d_i_ready", j), i_req_ready, 1);
            q_i.push_back(mk_resp(32'hDEADBEEF, 1'b0));
            $display("txn stall cycle %0d I granted", j);
            next_cycle();
        end
        i_req_valid = 1'b0; d_resp_ready = 1'b1;
        @(negedge clock);
        chk("stall_release_d_ready", d_req_ready, 1);
        q_d.push_back(mk_resp(32'hA5332211, 1'b0));
        next_cycle();
        d_req_valid = 1'b0;
        @(negedge clock);
        next_cycle();
        d_resp_ready = 1'b0; i_resp_ready = 1'b0;

        // Reset one cycle after a D grant: buffered response dropped, no write.
        d_req_valid = 1'b1;
        @(negedge clock);
        chk("rmid_grant", d_req_ready, 1);
        next_cycle();
        reset = 1'b1;
        d_req = mk_req(32'h300, 32'h12345678, MEM_OP_WRITE, MEM_ACCESS_WORD, 0);
        @(negedge clock);
        chk("rmid_d_ready", d_req_ready, 0);
        chk("rmid_mem_op", mem_params.op, MEM_OP_READ);
        chk("rmid_mem_addr", mem_address, 0);
        next_cycle();
        reset = 1'b0; d_req_valid = 1'b0;
        @(negedge clock);
        chk("rmid_d_resp_valid", d_resp_valid, 0);
        chk("rmid_i_resp_valid", i_resp_valid, 0);
        chk("rmid_mem_untouched", {mem_arr[10'h303], mem_arr[10'h302], mem_arr[10'h301], mem_arr[10'h300]}, 0);
        q_d.delete();
        next_cycle();
        run_vec(mk_vec(1, 32'h300, 32'h0, MEM_OP_READ, MEM_ACCESS_WORD, 0, 32'h0, 0), 99);

        chk("q_i_drained", q_i.size(), 0);
        chk("q_d_drained", q_d.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-ported `mem` block. It shares `mem` between the instruction-fetch port (I) and the load/store port (D). It accepts one request per cycle under valid/ready handshakes and drives `mem` only for the granted request; idle cycles are forced to harmless reads. Each port's result is held in a registered response buffer until that port consumes it. It sits between the core pipeline and `mem`, beside the reset-time setup path.

## Interface
Parameters:
- `MAX_D_STREAK`, default 4: consecutive D grants allowed while I is waiting before I is forced through; legal range 1..15.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `i_req_valid`  in  1  I request present.
- `i_req_ready`  out  1  I request accepted this cycle.
- `i_req`  in  mem_req_t  I request; `params.op` is always READ; a write on I is flagged as an error.
- `i_resp_valid`  out  1  I response buffered.
- `i_resp_ready`  in  1  I consumes the response.
- `i_resp`  out  mem_resp_t  I read data and error flag.
- `d_req_valid`, `d_req_ready`, `d_req`, `d_resp_valid`, `d_resp_ready`, `d_resp`: same as the I port, for D; writes are allowed.
- `mem_address`  out  arch_reg  to `mem.address`.
- `mem_data_in`  out  arch_reg  to `mem.data_in`.
- `mem_params`  out  mem_params_t  to `mem.params`.
- `mem_data_out`  in  arch_reg  from `mem.data_out`.

## Operation
- Eligibility: a port is eligible when `req_valid` is high and its response buffer is empty, or is emptied this cycle by `resp_ready`. At most one request is outstanding per port.
- Grant rule, one grant per cycle:
  - If D is eligible and `streak < MAX_D_STREAK` or I is not eligible, grant D.
  - Otherwise grant I if eligible.
- `streak` counter (4 bits):
  - increments on a D grant while I has `req_valid` high;
  - clears on an I grant, or on any cycle in which I has `req_valid` low;
  - saturates at `MAX_D_STREAK`.
- `req_ready` is high only for the granted port. It depends combinationally on both `req_valid`s and the buffer state.
- Granted request: `mem_address`, `mem_data_in` and `mem_params` are driven from the request in the same cycle. Read data from `mem_data_out` is captured into that port's buffer at the closing clock edge.
- Error check, done before driving `mem`:
  - `access_size == MEM_ACCESS_RSVD`;
  - HALF with `address[0]` set;
  - WORD with `address[1:0]` nonzero;
  - a write on I.
- An errored request is accepted, but `mem` gets the idle drive (no write). The buffer is loaded with `error=1` and `rdata=0`.
- Write response: `error=0`, `rdata=0`. It acts as an acknowledgement only.
- Idle drive, used when there is no grant, during reset, or for an errored request: op=MEM_OP_READ, size=MEM_ACCESS_WORD, address=0, data_in=0. This guarantees `mem` never sees a spurious write.

## Timing
- Request latency: accepted at edge T, `resp_valid` high from cycle T+1. The response holds until the cycle in which `resp_ready` is high.
- Back-to-back: a port whose buffer is consumed in cycle C may be granted in C. Throughput is one access per cycle total.
- Writes commit in `mem` at the edge ending the grant cycle. A D read granted the next cycle sees the new data.
- Reset values:
  - `req_ready`=0 for both ports;
  - `resp_valid`=0 for both ports;
  - `resp` data=0, error=0;
  - `streak`=0;
  - `mem` outputs at idle drive.
- During reset nothing is granted, so the `mem` setup-write path owns the array.
- Reset asserted mid-operation: buffered responses are discarded. Requesters must reissue after reset.
- Simultaneous `resp_ready` and a new grant on the same port: the buffer is overwritten with the new response, and `resp_valid` stays high.
- `resp_ready` while `resp_valid` is low is ignored.

## Structure
- Add to `mem_pkg`:
  - `mem_req_t` {address: arch_reg, wdata: arch_reg, params: mem_params_t};
  - `mem_resp_t` {rdata: arch_reg, error: logic};
  - `mem_port_t` enum {MEM_PORT_I, MEM_PORT_D};
  - function `mem_misaligned(address, access_size)`.
- Sub-module `mem_resp_buf`: a one-entry response register with valid, load and consume inputs. It is instantiated once per port.
- Grant logic and `streak` live in `mem_arbiter`.

## Test plan
- I reads word 0x100 (preloaded 0xDEADBEEF) while D is idle -> `i_req_ready` in cycle 0; `i_resp` = 0xDEADBEEF with error=0 in cycle 1.
- D writes byte 0xA5 to 0x203, then reads a signed byte from 0x203 on the next cycle -> the read returns 0xFFFFFFA5, and bytes 0x200–0x202 are unchanged.
- I and D both valid continuously, `MAX_D_STREAK`=4, responses consumed each cycle -> grant sequence D,D,D,D,I,D,D,D,D,I…
- D WORD read at 0x102, then an I write request -> both accepted with error=1 and rdata=0; `mem` op stays READ, and memory is unchanged.
- D `resp_ready` held low for 3 cycles with `d_req_valid` high -> `d_req_ready` stays 0 and `d_resp` is stable; I is still granted meanwhile.
- Reset pulsed one cycle after a D grant -> `d_resp_valid`=0 after reset, and no write reaches `mem` during reset.
